// File: rtl/trace_port_arbiter.sv
// Round-robin arbiter feeding one registered trace output, with run-time
// capture on/off control and a word budget that parks the stream in LIMIT.
module trace_port_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int LIMIT_W = 16,
  parameter int SRC_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      dump_on,
  input  logic                      dump_off,
  input  logic                      limit_load,
  input  logic [LIMIT_W-1:0]        limit_value,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  input  logic                      out_ready,
  output logic [1:0]                state,
  output logic                      limit_hit,
  output logic [LIMIT_W-1:0]        emit_cnt,
  output logic [LIMIT_W-1:0]        drop_cnt
);

  localparam int CNT_W = $clog2(N_REQ + 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ON    = 2'd1,
    ST_LIMIT = 2'd2
  } state_t;

  state_t             cur_st;
  state_t             nxt_st;
  logic [SRC_W-1:0]   ptr;
  logic [LIMIT_W-1:0] limit_q;
  logic [SRC_W-1:0]   win_idx;
  logic               win_found;
  logic               grant;
  logic               limit_reached;

  function automatic logic [CNT_W-1:0] popcount(input logic [N_REQ-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [LIMIT_W-1:0] sat_add(input logic [LIMIT_W-1:0] a,
                                                 input logic [CNT_W-1:0]   b);
    logic [LIMIT_W+CNT_W-1:0] s;
    s = (LIMIT_W+CNT_W)'(a) + (LIMIT_W+CNT_W)'(b);
    if (|s[LIMIT_W+CNT_W-1:LIMIT_W]) return '1;
    else return s[LIMIT_W-1:0];
  endfunction

  assign state = cur_st;

  // Round-robin search: first valid requester at or above the pointer, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && req_valid[(int'(ptr) + k) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = SRC_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_st <= ST_OFF;
    else        cur_st <= nxt_st;
  end

  assign limit_reached = grant && (limit_q != '0) &&
                         ((emit_cnt + 1'b1) == limit_q);

  always_comb begin
    nxt_st = cur_st;
    if (dump_off) begin
      nxt_st = ST_OFF;
    end else if (limit_load) begin
      if (dump_on)                  nxt_st = ST_ON;
      else if (cur_st == ST_LIMIT)  nxt_st = ST_OFF;
    end else if (dump_on && (cur_st == ST_OFF)) begin
      nxt_st = ST_ON;
    end else if ((cur_st == ST_ON) && limit_reached) begin
      nxt_st = ST_LIMIT;
    end
  end

  // OFF/LIMIT swallow every offered word; ON hands one slot to the winner
  always_comb begin
    req_ready = '0;
    grant     = 1'b0;
    limit_hit = (cur_st == ST_LIMIT);
    if (cur_st == ST_ON) begin
      if ((!out_valid || out_ready) && win_found) begin
        grant              = 1'b1;
        req_ready[win_idx] = 1'b1;
      end
    end else begin
      req_ready = req_valid;
    end
    if (!rst_n) begin
      req_ready = '0;
      grant     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      limit_q  <= '0;
      emit_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (grant) begin
        if (int'(win_idx) == N_REQ - 1) ptr <= '0;
        else                            ptr <= win_idx + 1'b1;
      end
      if (limit_load) begin
        limit_q  <= limit_value;
        emit_cnt <= '0;
      end else if (grant) begin
        emit_cnt <= emit_cnt + 1'b1;
      end
      if (cur_st != ST_ON) drop_cnt <= sat_add(drop_cnt, popcount(req_valid));
    end
  end

  // Output register stage: loads on grant, otherwise drains when the sink accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= req_data[int'(win_idx)*DATA_W +: DATA_W];
      out_src   <= win_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
